dma_read_req_splitter: RTL and testbench

- Sits directly upstream of the PCIe TX engine's DMA read request interface (dma_read_addr/len/valid/done).
- Accepts one read descriptor (start address, length in DW) at a time.
- Splits each descriptor into Memory Read requests. No request exceeds the max read request size, and no request crosses a 4 KB boundary.
- Throttles issue against a limit on outstanding requests, which the RX completion side releases.

---
 rtl/xilinx_pcie_dma_pkg.sv | 20 ++
 rtl/dma_read_chunk_calc.sv | 24 ++
 rtl/dma_read_req_splitter.sv | 131 +++++++++++++
 tb/tb_dma_read_req_splitter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xilinx_pcie_dma_pkg.sv
// Shared types and constants for the PCIe DMA read request path.
// Holds FSM encodings, the 4 KB boundary and the 10-bit length rule.
package xilinx_pcie_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_WAIT_LOW
    } state_t;

    localparam int unsigned BOUNDARY_BYTES = 4096;
    localparam int unsigned DW_SHIFT       = 2;

    // A 1024 DW request is carried as 0 in the 10-bit length field.
    function automatic logic [9:0] encode_len(input logic [12:0] chunk);
        return (chunk >= 13'd1024) ? 10'd0 : chunk[9:0];
    endfunction

endpackage

// File: rtl/dma_read_chunk_calc.sv
// Size of the next read request: the smallest of the remaining
// length, the MRRS limit and the distance to the next 4 KB page.
module dma_read_chunk_calc
    import xilinx_pcie_dma_pkg::*;
#(
    parameter int unsigned P_MRRS_BYTES = 512
) (
    input  logic [11:0] addr_lo,
    input  logic [15:0] rem,
    output logic [12:0] chunk
);

    localparam logic [12:0] MRRS_DW = 13'(P_MRRS_BYTES >> DW_SHIFT);

    logic [12:0] bound_dw;
    logic [12:0] rem_cap;

    always_comb begin
        bound_dw = (13'(BOUNDARY_BYTES) - {1'b0, addr_lo}) >> DW_SHIFT;
        rem_cap  = (rem > 16'(MRRS_DW)) ? MRRS_DW : rem[12:0];
        chunk    = (rem_cap < bound_dw) ? rem_cap : bound_dw;
    end

endmodule

// File: rtl/dma_read_req_splitter.sv
// Splits read descriptors into MRRS- and 4 KB-bounded memory reads,
// throttled by the number of requests still awaiting completion.
module dma_read_req_splitter
    import xilinx_pcie_dma_pkg::*;
#(
    parameter int unsigned P_MRRS_BYTES      = 512,
    parameter int unsigned P_MAX_OUTSTANDING = 8,
    parameter int unsigned P_CNT_WIDTH       = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [31:0]            desc_addr,
    input  logic [15:0]            desc_len_dw,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    output logic                   desc_done,
    output logic                   busy,
    output logic [31:0]            dma_read_addr,
    output logic [9:0]             dma_read_len,
    output logic                   dma_read_valid,
    input  logic                   dma_read_done,
    input  logic                   cpl_req_done,
    output logic [P_CNT_WIDTH-1:0] outstanding
);

    state_t      state;
    logic [31:0] cur_addr;
    logic [15:0] rem;
    logic [12:0] chunk;
    logic [12:0] calc_chunk;
    logic        done_q;
    logic        accept;
    logic        cpl_take;
    logic        can_issue;

    dma_read_chunk_calc #(
        .P_MRRS_BYTES(P_MRRS_BYTES)
    ) u_calc (
        .addr_lo(cur_addr[11:0]),
        .rem    (rem),
        .chunk  (calc_chunk)
    );

    // The engine holds done high; only its rising edge counts.
    assign accept    = (state == ST_ISSUE) && dma_read_valid
                       && dma_read_done && !done_q;
    assign cpl_take  = cpl_req_done && (outstanding != '0);
    assign can_issue = outstanding < P_CNT_WIDTH'(P_MAX_OUTSTANDING);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= dma_read_done;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding <= '0;
        end else if (accept && !cpl_take) begin
            outstanding <= outstanding + 1'b1;
        end else if (!accept && cpl_take) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            cur_addr       <= '0;
            rem            <= '0;
            chunk          <= '0;
            desc_ready     <= 1'b1;
            desc_done      <= 1'b0;
            busy           <= 1'b0;
            dma_read_addr  <= '0;
            dma_read_len   <= '0;
            dma_read_valid <= 1'b0;
        end else begin
            desc_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (desc_valid) begin
                        cur_addr <= desc_addr & 32'hFFFF_FFFC;
                        rem      <= desc_len_dw;
                        if (desc_len_dw == '0) begin
                            desc_done <= 1'b1;
                        end else begin
                            state      <= ST_CALC;
                            desc_ready <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    chunk <= calc_chunk;
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!dma_read_valid) begin
                        if (can_issue) begin
                            dma_read_valid <= 1'b1;
                            dma_read_addr  <= cur_addr;
                            dma_read_len   <= encode_len(chunk);
                        end
                    end else if (accept) begin
                        dma_read_valid <= 1'b0;
                        cur_addr <= cur_addr + {17'd0, chunk, 2'b00};
                        rem      <= rem - {3'd0, chunk};
                        state    <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!dma_read_done) begin
                        if (rem == '0) begin
                            desc_done  <= 1'b1;
                            busy       <= 1'b0;
                            desc_ready <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_read_req_splitter.sv
// Directed bench for the read request splitter and its chunk calculator.
// Main instance: MRRS 512, two outstanding; second instance: MRRS 4096.
module tb_dma_read_req_splitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d_addr;
    logic [15:0] d_len;
    logic        d_valid;
    logic        d_ready;
    logic        d_done;
    logic        busy;
    logic [31:0] rd_addr;
    logic [9:0]  rd_len;
    logic        rd_valid;
    logic        rd_done;
    logic        cpl;
    logic [7:0]  outstanding;

    logic [31:0] b_d_addr;
    logic [15:0] b_d_len;
    logic        b_d_valid;
    logic        b_d_ready;
    logic        b_d_done;
    logic        b_busy;
    logic [31:0] b_rd_addr;
    logic [9:0]  b_rd_len;
    logic        b_rd_valid;
    logic        b_rd_done;
    logic        b_cpl;
    logic [7:0]  b_outstanding;

    logic [11:0] c_addr_lo;
    logic [15:0] c_rem;
    logic [12:0] c_chunk;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dma_read_req_splitter #(
        .P_MRRS_BYTES(512),
        .P_MAX_OUTSTANDING(2),
        .P_CNT_WIDTH(8)
    ) u_dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .desc_addr(d_addr),
        .desc_len_dw(d_len),
        .desc_valid(d_valid),
        .desc_ready(d_ready),
        .desc_done(d_done),
        .busy(busy),
        .dma_read_addr(rd_addr),
        .dma_read_len(rd_len),
        .dma_read_valid(rd_valid),
        .dma_read_done(rd_done),
        .cpl_req_done(cpl),
        .outstanding(outstanding)
    );

    dma_read_req_splitter #(
        .P_MRRS_BYTES(4096),
        .P_MAX_OUTSTANDING(8),
        .P_CNT_WIDTH(8)
    ) u_big (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .desc_addr(b_d_addr),
        .desc_len_dw(b_d_len),
        .desc_valid(b_d_valid),
        .desc_ready(b_d_ready),
        .desc_done(b_d_done),
        .busy(b_busy),
        .dma_read_addr(b_rd_addr),
        .dma_read_len(b_rd_len),
        .dma_read_valid(b_rd_valid),
        .dma_read_done(b_rd_done),
        .cpl_req_done(b_cpl),
        .outstanding(b_outstanding)
    );

    dma_read_chunk_calc #(
        .P_MRRS_BYTES(512)
    ) u_calc (
        .addr_lo(c_addr_lo),
        .rem(c_rem),
        .chunk(c_chunk)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [15:0] l);
        d_addr  = a;
        d_len   = l;
        d_valid = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (rd_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    endtask

    task automatic accept_req(input string tag, input logic [31:0] ea,
                              input logic [9:0] el, input int hold,
                              input logic with_cpl, input logic [31:0] eo);
        wait_valid(tag);
        chk({tag, "_addr"}, rd_addr, ea);
        chk({tag, "_len"}, 32'(rd_len), 32'(el));
        rd_done = 1'b1;
        cpl     = with_cpl;
        @(posedge clk); #1;
        cpl = 1'b0;
        chk({tag, "_out"}, 32'(outstanding), eo);
        repeat (hold - 1) begin
            @(posedge clk); #1;
        end
        chk({tag, "_vlow"}, 32'(rd_valid), 32'd0);
        rd_done = 1'b0;
    endtask

    task automatic wait_desc_done(input string tag);
        int n;
        n = 0;
        while (d_done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done"}, 32'(d_done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy"}, 32'(d_ready), 32'd1);
    endtask

    task automatic cpl_pulse(input string tag, input logic [31:0] eo);
        cpl = 1'b1;
        @(posedge clk); #1;
        cpl = 1'b0;
        chk(tag, 32'(outstanding), eo);
    endtask

    initial begin
        int n;
        int hi;
        rst_n = 1'b0;
        d_addr = '0; d_len = '0; d_valid = 1'b0;
        rd_done = 1'b0; cpl = 1'b0;
        b_d_addr = '0; b_d_len = '0; b_d_valid = 1'b0;
        b_rd_done = 1'b0; b_cpl = 1'b0;
        c_addr_lo = '0; c_rem = '0;

        // chunk calculator vectors
        c_addr_lo = 12'hFFC; c_rem = 16'd100; #1;
        chk("calc_edge", 32'(c_chunk), 32'd1);
        c_addr_lo = 12'h000; c_rem = 16'd2000; #1;
        chk("calc_mrrs", 32'(c_chunk), 32'd128);
        c_addr_lo = 12'h100; c_rem = 16'd5; #1;
        chk("calc_rem", 32'(c_chunk), 32'd5);
        c_addr_lo = 12'hF00; c_rem = 16'd300; #1;
        chk("calc_4k", 32'(c_chunk), 32'd64);
        c_addr_lo = 12'hE00; c_rem = 16'hFFFF; #1;
        chk("calc_tie", 32'(c_chunk), 32'd128);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(d_ready), 32'd1);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(d_done), 32'd0);
        chk("rst_out", 32'(outstanding), 32'd0);
        chk("rst_addr", rd_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // even split
        send(32'h0000_1000, 16'd256);
        chk("even_busy", 32'(busy), 32'd1);
        chk("even_nrdy", 32'(d_ready), 32'd0);
        accept_req("even1", 32'h0000_1000, 10'd128, 1, 1'b0, 32'd1);
        accept_req("even2", 32'h0000_1200, 10'd128, 1, 1'b0, 32'd2);
        wait_desc_done("even");
        chk("even_out", 32'(outstanding), 32'd2);
        cpl_pulse("even_c1", 32'd1);
        cpl_pulse("even_c0", 32'd0);
        cpl_pulse("sat0", 32'd0);

        // 4 KB crossing
        send(32'h0000_0F80, 16'd64);
        accept_req("x4k1", 32'h0000_0F80, 10'd32, 1, 1'b0, 32'd1);
        accept_req("x4k2", 32'h0000_1000, 10'd32, 1, 1'b0, 32'd2);
        wait_desc_done("x4k");
        cpl_pulse("x4k_c1", 32'd1);
        cpl_pulse("x4k_c0", 32'd0);

        // throttle at two outstanding
        send(32'h0000_0000, 16'd512);
        accept_req("thr1", 32'h0000_0000, 10'd128, 1, 1'b0, 32'd1);
        accept_req("thr2", 32'h0000_0200, 10'd128, 1, 1'b0, 32'd2);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rd_valid) hi++;
        end
        chk("thr_stall", 32'(hi), 32'd0);
        chk("thr_busy", 32'(busy), 32'd1);
        cpl_pulse("thr_c1", 32'd1);
        accept_req("thr3", 32'h0000_0400, 10'd128, 1, 1'b0, 32'd2);
        cpl_pulse("thr_c2", 32'd1);
        accept_req("thr4", 32'h0000_0600, 10'd128, 1, 1'b1, 32'd1);
        wait_desc_done("thr");
        cpl_pulse("thr_c3", 32'd0);

        // held acknowledge
        send(32'h0000_2000, 16'd256);
        accept_req("hold1", 32'h0000_2000, 10'd128, 5, 1'b0, 32'd1);
        accept_req("hold2", 32'h0000_2200, 10'd128, 5, 1'b0, 32'd2);
        wait_desc_done("hold");
        chk("hold_out", 32'(outstanding), 32'd2);
        cpl_pulse("hold_c1", 32'd1);
        cpl_pulse("hold_c0", 32'd0);

        // zero length
        send(32'h0000_3000, 16'd0);
        chk("zero_done", 32'(d_done), 32'd1);
        chk("zero_valid", 32'(rd_valid), 32'd0);
        chk("zero_rdy", 32'(d_ready), 32'd1);
        @(posedge clk); #1;
        chk("zero_pulse", 32'(d_done), 32'd0);
        chk("zero_valid2", 32'(rd_valid), 32'd0);

        // 1024 DW request on the 4096-byte MRRS instance
        b_d_addr = 32'h0000_0000; b_d_len = 16'd1024; b_d_valid = 1'b1;
        @(posedge clk); #1;
        b_d_valid = 1'b0;
        n = 0;
        while (b_rd_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("big_valid", 32'(b_rd_valid), 32'd1);
        chk("big_addr", b_rd_addr, 32'd0);
        chk("big_len", 32'(b_rd_len), 32'd0);
        b_rd_done = 1'b1;
        @(posedge clk); #1;
        b_rd_done = 1'b0;
        chk("big_out", 32'(b_outstanding), 32'd1);
        n = 0;
        while (b_d_done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("big_done", 32'(b_d_done), 32'd1);

        // reset in the middle of a descriptor
        send(32'h0000_4000, 16'd256);
        accept_req("rs1", 32'h0000_4000, 10'd128, 1, 1'b0, 32'd1);
        wait_valid("rs2");
        #3;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 32'(rd_valid), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_out", 32'(outstanding), 32'd0);
        chk("rs_big_out", 32'(b_outstanding), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rs_rdy", 32'(d_ready), 32'd1);
        send(32'h0000_5000, 16'd4);
        accept_req("rs3", 32'h0000_5000, 10'd4, 1, 1'b0, 32'd1);
        wait_desc_done("rs3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
